// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified IF/D memory port arbiter.
package unified_mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
   typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
   localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              d_req;
   logic              d_we;
   logic [3:0]        d_be;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              stall_f;
   logic              stall_m;
   logic              err_timeout;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_be, mem_addr,
             mem_wdata, stall_f, stall_m, err_timeout
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_be, mem_addr,
             mem_wdata, stall_f, stall_m, err_timeout
   );
endinterface

// File: rtl/unified_mem_arbiter_mem_wait_timer.sv
// Counts cycles spent waiting for mem_ack; expired_o flags the abort cycle.
module mem_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int TW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == TW'(MAX_WAIT));

   // Saturates so a held enable cannot wrap back below the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (en_i && !expired_o)
         cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one memory port between fetch (IF) and data (D) requesters,
// registering the winner and returning data with a one-cycle ready pulse.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4,
   parameter int MAX_WAIT   = 15
) (
   input logic                  clk,
   input logic                  reset,
   unified_mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIM + 1);

   arb_state_t        state_q, state_d;
   arb_owner_t        owner_q, owner_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              d_ready_q, d_ready_d;
   logic              err_q, err_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              expired;
   logic              force_if;

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (state_q != BUSY),
      .en_i      (state_q == BUSY),
      .expired_o (expired)
   );

   // Fetch has been passed over STARVE_LIM times in a row: it wins this once.
   assign force_if = bus.if_req && (starve_q == SW'(STARVE_LIM));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;
      err_d       = 1'b0;
      starve_d    = starve_q;
      case (state_q)
         IDLE: begin
            if (bus.d_req && !force_if) begin
               state_d     = BUSY;
               owner_d     = OWN_D;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_be_d    = bus.d_we ? bus.d_be : BE_FULL;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               if (!bus.if_req)
                  starve_d = '0;
               else if (starve_q != SW'(STARVE_LIM))
                  starve_d = starve_q + SW'(1);
            end else if (bus.if_req) begin
               state_d     = BUSY;
               owner_d     = OWN_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_be_d    = BE_FULL;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = '0;
               starve_d    = '0;
            end
         end
         BUSY: begin
            // An ack arriving on the expiry cycle still completes normally.
            if (bus.mem_ack) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               if (owner_q == OWN_D) begin
                  d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                  d_ready_d = 1'b1;
               end else begin
                  if_rdata_d = bus.mem_rdata;
                  if_ready_d = 1'b1;
               end
            end else if (expired) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               if (owner_q == OWN_D) begin
                  d_rdata_d = '0;
                  d_ready_d = 1'b1;
               end else begin
                  if_rdata_d = '0;
                  if_ready_d = 1'b1;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
         err_q       <= 1'b0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
         err_q       <= err_d;
         starve_q    <= starve_d;
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_be      = mem_be_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.if_ready    = if_ready_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.d_ready     = d_ready_q;
   assign bus.err_timeout = err_q;
   assign bus.stall_f     = bus.if_req & ~if_ready_q;
   assign bus.stall_m     = bus.d_req & ~d_ready_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: stimulus queues expected memory requests and responses,
// a monitor pops and compares whenever the arbiter presents them.
module tb_unified_mem_arbiter;
   import unified_mem_arbiter_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic        chk_wd;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic        is_d;
      logic [31:0] data;
      logic        err;
   } rsp_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } djob_t;

   logic clk;
   logic rst_n;

   unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   unified_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .MAX_WAIT(15)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   mem_exp_t    exp_mem[$];
   rsp_exp_t    exp_rsp[$];
   logic [31:0] if_jobs[$];
   djob_t       d_jobs[$];
   logic        if_active = 1'b0;
   logic        d_active  = 1'b0;
   logic        abort     = 1'b0;
   logic        ack_en    = 1'b1;
   int          ack_dly   = 1;
   logic [31:0] mem_data  = 32'h0;
   logic        spur_ack  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_mem.size() != 0 || exp_rsp.size() != 0 || if_jobs.size() != 0 ||
              d_jobs.size() != 0 || if_active || d_active) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_drain: not complete after %0d cycles (got %0d cycles, expected < %0d)",
                  name, budget, n, budget);
      end
   endtask

   // Fetch requester: holds if_req until it sees if_ready, then drops or moves on.
   initial begin : if_agent
      logic rdy;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      forever begin
         @(negedge clk);
         rdy = bus.if_ready;
         @(posedge clk);
         #1;
         if (abort) begin
            if_active  = 1'b0;
            bus.if_req = 1'b0;
         end else begin
            if (if_active && rdy) begin
               if_active  = 1'b0;
               bus.if_req = 1'b0;
            end
            if (!if_active && if_jobs.size() > 0) begin
               bus.if_addr = if_jobs.pop_front();
               bus.if_req  = 1'b1;
               if_active   = 1'b1;
            end
         end
      end
   end

   initial begin : d_agent
      logic  rdy;
      djob_t j;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_be    = '0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      forever begin
         @(negedge clk);
         rdy = bus.d_ready;
         @(posedge clk);
         #1;
         if (abort) begin
            d_active  = 1'b0;
            bus.d_req = 1'b0;
         end else begin
            if (d_active && rdy) begin
               d_active  = 1'b0;
               bus.d_req = 1'b0;
            end
            if (!d_active && d_jobs.size() > 0) begin
               j           = d_jobs.pop_front();
               bus.d_addr  = j.addr;
               bus.d_we    = j.we;
               bus.d_be    = j.be;
               bus.d_wdata = j.wdata;
               bus.d_req   = 1'b1;
               d_active    = 1'b1;
            end
         end
      end
   end

   // Memory: acks on the ack_dly-th cycle of a request, or never when ack_en is low.
   initial begin : mem_model
      int n;
      n = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ack   = spur_ack;
         bus.mem_rdata = mem_data;
         if (bus.mem_req && ack_en) begin
            if (n == ack_dly - 1) begin
               bus.mem_ack = 1'b1;
               n = 0;
            end else begin
               n++;
            end
         end else begin
            n = 0;
         end
      end
   end

   initial begin : monitor
      logic        prev_req;
      logic [31:0] rd;
      mem_exp_t    m;
      rsp_exp_t    r;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_req = 1'b0;
         end else begin
            if (bus.mem_req && !prev_req) begin
               checks++;
               if (exp_mem.size() == 0) begin
                  errors++;
                  $display("FAIL mem_unexpected: got request addr=%0h expected no request", bus.mem_addr);
               end else begin
                  m = exp_mem.pop_front();
                  if (bus.mem_addr !== m.addr || bus.mem_we !== m.we || bus.mem_be !== m.be ||
                      (m.chk_wd && bus.mem_wdata !== m.wdata)) begin
                     errors++;
                     $display("FAIL mem_req: got addr=%0h we=%0b be=%0h wd=%0h expected addr=%0h we=%0b be=%0h wd=%0h",
                              bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata,
                              m.addr, m.we, m.be, m.wdata);
                  end
               end
            end
            prev_req = bus.mem_req;
            if (bus.if_ready || bus.d_ready) begin
               checks++;
               rd = bus.d_ready ? bus.d_rdata : bus.if_rdata;
               if (exp_rsp.size() == 0) begin
                  errors++;
                  $display("FAIL rsp_unexpected: got if_ready=%0b d_ready=%0b expected none",
                           bus.if_ready, bus.d_ready);
               end else begin
                  r = exp_rsp.pop_front();
                  if (bus.d_ready !== r.is_d || bus.if_ready !== !r.is_d ||
                      rd !== r.data || bus.err_timeout !== r.err) begin
                     errors++;
                     $display("FAIL rsp: got if_rdy=%0b d_rdy=%0b data=%0h err=%0b expected d_owner=%0b data=%0h err=%0b",
                              bus.if_ready, bus.d_ready, rd, bus.err_timeout, r.is_d, r.data, r.err);
                  end
               end
            end else if (bus.err_timeout) begin
               checks++;
               errors++;
               $display("FAIL err_alone: got err_timeout=1 expected it only alongside a ready pulse");
            end
         end
      end
   end

   initial begin : stim
      int cnt, n;
      logic seen;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req",   bus.mem_req, 0);
      chk("rst_mem_we",    bus.mem_we, 0);
      chk("rst_mem_be",    bus.mem_be, 0);
      chk("rst_mem_addr",  bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_if_rdata",  bus.if_rdata, 0);
      chk("rst_d_rdata",   bus.d_rdata, 0);
      chk("rst_if_ready",  bus.if_ready, 0);
      chk("rst_d_ready",   bus.d_ready, 0);
      chk("rst_err",       bus.err_timeout, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single fetch, ack in second BUSY cycle.
      @(negedge clk);
      ack_dly  = 2;
      mem_data = 32'hE3A01005;
      exp_mem.push_back(mem_exp_t'{32'h100, 1'b0, 4'hF, 1'b0, 32'h0});
      exp_rsp.push_back(rsp_exp_t'{1'b0, 32'hE3A01005, 1'b0});
      if_jobs.push_back(32'h100);
      wait_drain("fetch", 50);

      // Simultaneous requests: D store wins, fetch waits with stall_f high.
      @(negedge clk);
      ack_dly  = 1;
      mem_data = 32'h11112222;
      exp_mem.push_back(mem_exp_t'{32'h2000, 1'b1, 4'b0011, 1'b1, 32'hDEADBEEF});
      exp_mem.push_back(mem_exp_t'{32'h104, 1'b0, 4'hF, 1'b0, 32'h0});
      exp_rsp.push_back(rsp_exp_t'{1'b1, 32'h0, 1'b0});
      exp_rsp.push_back(rsp_exp_t'{1'b0, 32'h11112222, 1'b0});
      d_jobs.push_back(djob_t'{32'h2000, 1'b1, 4'b0011, 32'hDEADBEEF});
      if_jobs.push_back(32'h104);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("stall_f_while_d", bus.stall_f, 1);
      chk("stall_m_while_d", bus.stall_m, 1);
      wait_drain("contend", 60);
      chk("stall_f_after", bus.stall_f, 0);

      // Starvation: four D grants, then fetch is forced through, then last D.
      @(negedge clk);
      mem_data = 32'h0BADF00D;
      for (int i = 0; i < 5; i++) begin
         d_jobs.push_back(djob_t'{32'h3000 + 32'(4 * i), 1'b0, 4'b0101, 32'h55});
         if (i == 4)
            exp_mem.push_back(mem_exp_t'{32'h200, 1'b0, 4'hF, 1'b0, 32'h0});
         exp_mem.push_back(mem_exp_t'{32'h3000 + 32'(4 * i), 1'b0, 4'hF, 1'b0, 32'h0});
      end
      for (int i = 0; i < 6; i++)
         exp_rsp.push_back(rsp_exp_t'{(i != 4), 32'h0BADF00D, 1'b0});
      if_jobs.push_back(32'h200);
      wait_drain("starve", 120);

      // No ack: 16 BUSY cycles (wait count 0..15), then abort with rdata 0.
      @(negedge clk);
      ack_en = 1'b0;
      exp_mem.push_back(mem_exp_t'{32'h4000, 1'b0, 4'hF, 1'b0, 32'h0});
      exp_rsp.push_back(rsp_exp_t'{1'b1, 32'h0, 1'b1});
      d_jobs.push_back(djob_t'{32'h4000, 1'b0, 4'hF, 32'h0});
      cnt = 0; seen = 1'b0; n = 0;
      while (n < 60 && !(seen && !bus.mem_req)) begin
         @(negedge clk);
         n++;
         if (bus.mem_req) begin
            seen = 1'b1;
            cnt++;
         end
      end
      chk("timeout_busy_cycles", 32'(cnt), 32'd16);
      wait_drain("timeout", 40);
      ack_en = 1'b1;

      // Ack landing on the expiry cycle completes normally.
      @(negedge clk);
      ack_dly  = 16;
      mem_data = 32'h12345678;
      exp_mem.push_back(mem_exp_t'{32'h300, 1'b0, 4'hF, 1'b0, 32'h0});
      exp_rsp.push_back(rsp_exp_t'{1'b0, 32'h12345678, 1'b0});
      if_jobs.push_back(32'h300);
      wait_drain("ack_on_expiry", 60);

      // Spurious ack in IDLE is ignored.
      @(negedge clk);
      spur_ack = 1'b1;
      @(negedge clk);
      spur_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("spur_mem_req", bus.mem_req, 0);
      chk("spur_ready", {bus.if_ready, bus.d_ready}, 0);
      ack_dly  = 1;
      mem_data = 32'hCAFEF00D;
      exp_mem.push_back(mem_exp_t'{32'h400, 1'b0, 4'hF, 1'b0, 32'h0});
      exp_rsp.push_back(rsp_exp_t'{1'b0, 32'hCAFEF00D, 1'b0});
      if_jobs.push_back(32'h400);
      wait_drain("after_spur", 50);

      // Reset while BUSY: mem_req drops asynchronously, nothing replayed.
      @(negedge clk);
      ack_en = 1'b0;
      exp_mem.push_back(mem_exp_t'{32'h5000, 1'b1, 4'hF, 1'b1, 32'h1});
      d_jobs.push_back(djob_t'{32'h5000, 1'b1, 4'hF, 32'h1});
      n = 0;
      while (!bus.mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_busy_reached", bus.mem_req, 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      abort = 1'b1;
      #1 chk("rst_async_mem_req", bus.mem_req, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      abort  = 1'b0;
      ack_en = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.mem_req || bus.if_ready || bus.d_ready) cnt++;
      end
      chk("post_rst_activity", 32'(cnt), 0);
      chk("exp_mem_left", 32'(exp_mem.size()), 0);
      chk("exp_rsp_left", 32'(exp_rsp.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule
